// File: rtl/menu_pkg.sv
// Shared definitions for the menu key conditioner.
// Key indices, key FSM encoding and a sizing helper.
package menu_pkg;

  localparam int KEY_ENTER = 0;
  localparam int KEY_ESC   = 1;
  localparam int KEY_RIGHT = 2;
  localparam int KEY_LEFT  = 3;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } key_state_e;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: synchroniser, debounce FSM and
// optional auto-repeat timer producing single-cycle events.
module key_debounce
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic held,
  output logic fire
);

  localparam int CW =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY,
                REPEAT_PERIOD)) + 1;

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          pressed;
  key_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          press_fire;
  logic          rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_raw};
  end

  assign pressed = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Counters stop at DB_LAST, so they saturate there.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    press_fire = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pressed) begin
          state_n = S_PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pressed) begin
          state_n = S_IDLE;
        end else if (cnt >= DB_LAST) begin
          state_n    = S_HELD;
          press_fire = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!pressed) begin
          state_n = S_RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (pressed) begin
          state_n = S_HELD;
        end else if (cnt >= DB_LAST) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam logic [CW-1:0] DLY_LAST =
        CW'(REPEAT_DELAY - 1);
      localparam logic [CW-1:0] PER_LAST =
        CW'(REPEAT_PERIOD - 1);

      logic [CW-1:0] rcnt;
      logic          first;
      logic [CW-1:0] limit;

      assign limit    = first ? DLY_LAST : PER_LAST;
      assign rep_fire = (state == S_HELD) &&
                        (rcnt >= limit);

      // Timer only advances in HELD; release bounces pause it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt  <= '0;
          first <= 1'b1;
        end else if (press_fire) begin
          rcnt  <= '0;
          first <= 1'b1;
        end else if (rep_fire) begin
          rcnt  <= '0;
          first <= 1'b0;
        end else if (state == S_HELD) begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
  endgenerate

  assign held = (state == S_HELD) ||
                (state == S_RELEASE_WAIT);
  assign fire = press_fire | rep_fire;

endmodule

// File: rtl/menu_key_conditioner.sv
// Four debounced keys feeding pending flags and a
// priority arbiter that emits one command pulse per cycle.
module menu_key_conditioner
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] KeyIn,
  input  logic       Enable,
  output logic       Left,
  output logic       Right,
  output logic       Esc,
  output logic       Enter,
  output logic [3:0] KeyHeld
);

  logic [3:0] fire;
  logic [3:0] pend, pend_n;
  logic [3:0] grant;
  logic [3:0] pulse;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (k == KEY_LEFT || k == KEY_RIGHT)
    ) u_key (
      .clk    (Clock),
      .rst_n  (Resetn),
      .key_raw(KeyIn[k]),
      .held   (KeyHeld[k]),
      .fire   (fire[k])
    );
  end

  // Several flags may be set at once, so order matters here.
  always_comb begin
    grant = '0;
    priority case (1'b1)
      pend[KEY_LEFT]:  grant[KEY_LEFT]  = 1'b1;
      pend[KEY_RIGHT]: grant[KEY_RIGHT] = 1'b1;
      pend[KEY_ENTER]: grant[KEY_ENTER] = 1'b1;
      pend[KEY_ESC]:   grant[KEY_ESC]   = 1'b1;
      default:         grant = '0;
    endcase
  end

  always_comb begin
    pend_n = '0;
    if (Enable) pend_n = (pend & ~grant) | fire;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pend  <= '0;
      pulse <= '0;
    end else begin
      pend  <= pend_n;
      pulse <= Enable ? grant : 4'b0000;
    end
  end

  assign Left  = pulse[KEY_LEFT];
  assign Right = pulse[KEY_RIGHT];
  assign Esc   = pulse[KEY_ESC];
  assign Enter = pulse[KEY_ENTER];

endmodule

// File: tb/tb_menu_key_conditioner.sv
// Bench for menu_key_conditioner: directed scenarios plus
// random key/enable/reset traffic against a run-length model.
module tb_menu_key_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] KeyIn;
  logic       Enable;
  logic       Left, Right, Esc, Enter;
  logic [3:0] KeyHeld;

  menu_key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .KeyIn  (KeyIn),
    .Enable (Enable),
    .Left   (Left),
    .Right  (Right),
    .Esc    (Esc),
    .Enter  (Enter),
    .KeyHeld(KeyHeld)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  // Pulse vector indexed by key number: 3 Left, 2 Right, 1 Esc, 0 Enter.
  function automatic logic [3:0] pv();
    return {Left, Right, Esc, Enter};
  endfunction

  // Reference model: a key flips its accepted level after D+1
  // consecutive synchronised samples disagreeing with it.
  logic [3:0] m_p1, m_p2, m_acc, m_pend, m_out;
  int run[4];
  int hc[4];
  int nx[4];
  int prio[4] = '{3, 2, 0, 1};

  always @(posedge Clock or negedge Resetn) begin : model
    logic [3:0] ev;
    logic [3:0] gr;
    logic       pr;
    if (!Resetn) begin
      m_p1 = '0; m_p2 = '0; m_acc = '0;
      m_pend = '0; m_out = '0;
      for (int k = 0; k < 4; k++) begin
        run[k] = 0; hc[k] = 0; nx[k] = RD;
      end
    end else begin
      cyc++;
      ev = '0;
      for (int k = 0; k < 4; k++) begin
        pr = m_p2[k];
        if ((k == 2 || k == 3) && m_acc[k] && run[k] == 0) begin
          hc[k]++;
          if (hc[k] == nx[k]) begin
            ev[k] = 1'b1;
            nx[k] += RP;
          end
        end
        if (pr != m_acc[k]) begin
          run[k]++;
          if (run[k] == D + 1) begin
            m_acc[k] = pr;
            run[k] = 0;
            if (pr) begin
              ev[k] = 1'b1; hc[k] = 0; nx[k] = RD;
            end
          end
        end else begin
          run[k] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = ~KeyIn;
      gr = '0;
      for (int i = 0; i < 4; i++)
        if (gr == 4'b0000 && m_pend[prio[i]]) gr[prio[i]] = 1'b1;
      m_out  = Enable ? gr : 4'b0000;
      m_pend = Enable ? ((m_pend & ~gr) | ev) : 4'b0000;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      checks++;
      if (pv() !== m_out || KeyHeld !== m_acc) begin
        errors++;
        $display("FAIL cmp cyc %0d pulses %b want %b held %b want %b",
                 cyc, pv(), m_out, KeyHeld, m_acc);
      end
      checks++;
      if ($countones(pv()) > 1) begin
        errors++;
        $display("FAIL onehot cyc %0d pulses %b want at most one",
                 cyc, pv());
      end
    end
  end

  int fp[4], np[4], sp[4], fh[4], fl[4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic observe(input int n);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      fp[k] = 0; np[k] = 0; sp[k] = 0; fh[k] = 0; fl[k] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge Clock);
      p = pv();
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          np[k]++;
          if (np[k] == 1) fp[k] = i;
          if (np[k] == 2) sp[k] = i;
        end
        if (KeyHeld[k] && fh[k] == 0) fh[k] = i;
        if (!KeyHeld[k] && fl[k] == 0) fl[k] = i;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  int bounce_pulses;

  initial begin
    KeyIn  = 4'hF;
    Enable = 1'b1;
    Resetn = 1'b0;
    idle(3);
    chk("rst_pulses", int'(pv()), 0);
    chk("rst_held", int'(KeyHeld), 0);
    #1 Resetn = 1'b1;
    chk_en = 1'b1;
    idle(3);

    // Clean Enter press
    #1 KeyIn[0] = 1'b0;
    observe(30);
    chk("enter_first", fp[0], 8);
    chk("enter_count", np[0], 1);
    chk("enter_held", fh[0], 7);
    #1 KeyIn = 4'hF;
    idle(10);

    // Esc bounce then stable
    bounce_pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 0) begin
        #1 KeyIn[1] = logic'((j / 2) % 2);
      end
      @(negedge Clock);
      if (Esc) bounce_pulses++;
    end
    chk("esc_bounce", bounce_pulses, 0);
    #1 KeyIn[1] = 1'b0;
    observe(20);
    chk("esc_first", fp[1], 8);
    chk("esc_count", np[1], 1);
    #1 KeyIn = 4'hF;
    idle(10);

    // Left held with auto-repeat
    #1 KeyIn[3] = 1'b0;
    observe(38);
    chk("left_first", fp[3], 8);
    chk("left_repeat1", sp[3], 18);
    chk("left_count", np[3], 6);
    chk("left_held", fh[3], 7);
    #1 KeyIn = 4'hF;
    observe(20);
    chk("left_after_rel", np[3], 0);
    chk("left_held_fall", fl[3], 7);
    idle(5);

    // Left and Enter together
    #1 KeyIn = 4'b0110;
    observe(12);
    chk("both_left", fp[3], 8);
    chk("both_enter", fp[0], 9);
    chk("both_left_n", np[3], 1);
    chk("both_enter_n", np[0], 1);
    #1 KeyIn = 4'hF;
    idle(10);

    // Right accepted while disabled
    #1 Enable = 1'b0;
    KeyIn[2] = 1'b0;
    observe(10);
    chk("dis_right_a", np[2], 0);
    chk("dis_right_held", fh[2], 7);
    #1 KeyIn = 4'hF;
    observe(10);
    chk("dis_right_b", np[2], 0);
    #1 Enable = 1'b1;
    observe(15);
    chk("dis_right_c", np[2], 0);

    // Reset during Enter debounce
    #1 KeyIn[0] = 1'b0;
    idle(4);
    #1 Resetn = 1'b0;
    observe(3);
    chk("rst_mid_pulses", np[0] + np[1] + np[2] + np[3], 0);
    chk("rst_mid_held", fh[0], 0);
    #1 Resetn = 1'b1;
    observe(12);
    chk("rst_enter_first", fp[0], 8);
    chk("rst_enter_count", np[0], 1);
    #1 KeyIn = 4'hF;
    idle(10);

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      @(negedge Clock);
      #1;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 19) == 0) KeyIn[k] = ~KeyIn[k];
      Enable = ($urandom_range(0, 29) != 0);
      Resetn = ($urandom_range(0, 799) != 0);
    end
    #1 Resetn = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
